datamem_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the 512-word data memory. Port 0 is the CPU load/store stage and port 1 is the loader/debug master. One winner is selected and its command latched. The block then drives the memory's MemRead/MemWrite/Addr/Wdata pins for a programmable number of cycles, registers the read data, and returns a one-cycle acknowledge to the winner. Out-of-range addresses are rejected without touching memory.

---
 rtl/datamem_arbiter.sv | 124 ++++++++++++
 tb/tb_datamem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
// Latches one winning command, strobes the memory for MEM_LAT cycles, then acks.
module datamem_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] Addr,
  output logic [DATA_W-1:0] Wdata,
  input  logic [DATA_W-1:0] Rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              state_q;
  logic                cmd_port_q;
  logic                last_grant_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                ack0_q;
  logic                ack1_q;
  logic                mem_rd_q;
  logic                mem_wr_q;

  logic                grant_d;
  logic                sel_we_d;
  logic [DATA_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  logic                in_range_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_d     = (req0 && req1) ? ~last_grant_q : req1;
    sel_we_d    = grant_d ? we1    : we0;
    sel_addr_d  = grant_d ? addr1  : addr0;
    sel_wdata_d = grant_d ? wdata1 : wdata0;
    in_range_d  = sel_addr_d < DATA_W'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_port_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            cmd_port_q <= grant_d;
            addr_q     <= sel_addr_d;
            wdata_q    <= sel_wdata_d;
            err_q      <= ~in_range_d;
            mem_rd_q   <= in_range_d & ~sel_we_d;
            mem_wr_q   <= in_range_d & sel_we_d;
            cnt_q      <= LAT_M1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            // mem_rd_q is set only for an in-range read, so writes and rejects return 0.
            rdata_q  <= mem_rd_q ? Rdata : '0;
            ack0_q   <= ~cmd_port_q;
            ack1_q   <= cmd_port_q;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          ack0_q       <= 1'b0;
          ack1_q       <= 1'b0;
          last_grant_q <= cmd_port_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign MemRead  = mem_rd_q;
  assign MemWrite = mem_wr_q;
  assign Addr     = addr_q;
  assign Wdata    = wdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Scoreboard bench for datamem_arbiter: stimulus pushes expected acks, a monitor pops
// and compares them; strobe counts and latency are checked per access.
module tb_datamem_arbiter;

  localparam int LAT   = 3;
  localparam int DEPTH = 512;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, busy, MemRead, MemWrite;
  logic [31:0] rdata, Addr, Wdata, Rdata;

  logic        pre_en = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [0:DEPTH-1];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   ack_cyc[$];
  exp_t mon_e;

  datamem_arbiter #(.DATA_W(32), .DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr), .Wdata(Wdata),
    .Rdata(Rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (MemWrite && Addr < DEPTH) mem[Addr[8:0]] <= Wdata;
  end
  assign Rdata = (Addr < DEPTH) ? mem[Addr[8:0]] : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (ack0 || ack1)) begin
      ack_cyc.push_back(cyc);
      check("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_port", {31'b0, ack1}, {31'b0, mon_e.port});
        check("ack_rdata", rdata, mon_e.rdata);
        check("ack_err", {31'b0, err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic drive(input bit port, input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] d);
    if (port) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a[8:0]; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic do_access(input string tag, input bit port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] erd, input bit eerr, input bit hold);
    int rd_n = 0;
    int wr_n = 0;
    int lat = 0;
    int bad = 0;
    bit got = 1'b0;
    bit in_rng;
    in_rng = (addr < DEPTH);
    exp_q.push_back('{port, erd, eerr});
    if (hold) exp_q.push_back('{port, erd, eerr});
    @(negedge clk);
    drive(port, 1'b1, we, addr, wd);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (MemRead) rd_n++;
      if (MemWrite) wr_n++;
      if ((MemRead || MemWrite) && (Addr !== addr || (MemWrite && Wdata !== wd))) bad++;
      got = port ? ack1 : ack0;
    end
    check({tag, "_ack_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, lat, LAT + 1);
    check({tag, "_memread_cycles"}, rd_n, (!we && in_rng) ? LAT : 0);
    check({tag, "_memwrite_cycles"}, wr_n, (we && in_rng) ? LAT : 0);
    check({tag, "_addr_wdata"}, bad, 0);
    @(posedge clk);
    if (hold) begin
      @(posedge clk);
      #1 drive(port, 1'b0, we, addr, wd);
      @(negedge clk);
      check({tag, "_restart_strobe"}, {30'b0, MemWrite, MemRead}, we ? 32'd2 : 32'd1);
      check({tag, "_restart_addr"}, Addr, addr);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = port ? ack1 : ack0;
      end
      check({tag, "_ack2_seen"}, {31'b0, got}, 32'd1);
      @(posedge clk);
    end
    #1 drive(port, 1'b0, we, addr, wd);
  endtask

  task automatic contention();
    int s;
    exp_q.push_back('{1'b0, 32'h1111_1111, 1'b0});
    exp_q.push_back('{1'b1, 32'h2222_2222, 1'b0});
    exp_q.push_back('{1'b0, 32'h1111_1111, 1'b0});
    exp_q.push_back('{1'b1, 32'h2222_2222, 1'b0});
    s = ack_cyc.size();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd20, 32'd0);
    fork
      begin
        int n = 0;
        for (int i = 0; i < 60 && n < 2; i++) begin
          @(negedge clk);
          if (ack0) n++;
        end
        @(posedge clk);
        #1 req0 = 1'b0;
      end
      begin
        int m = 0;
        for (int j = 0; j < 60 && m < 2; j++) begin
          @(negedge clk);
          if (ack1) m++;
        end
        @(posedge clk);
        #1 req1 = 1'b0;
      end
    join
    check("contention_ack_count", ack_cyc.size() - s, 32'd4);
    if (ack_cyc.size() - s == 4) begin
      for (int k = 0; k < 3; k++)
        check("contention_spacing", ack_cyc[s+k+1] - ack_cyc[s+k], LAT + 2);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_access1_memread", {31'b0, MemRead}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_strobes", {30'b0, MemWrite, MemRead}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ack", {30'b0, ack1, ack0}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_ack_held", {30'b0, ack1, ack0}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ack", {30'b0, ack1, ack0}, 32'd0);
    check("rst_err_busy", {30'b0, err, busy}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_strobes", {30'b0, MemWrite, MemRead}, 32'd0);
    check("rst_addr", Addr, 32'd0);
    check("rst_wdata", Wdata, 32'd0);
    preload(5, 32'hDEAD_BEEF);
    preload(0, 32'hA5A5_A5A5);
    preload(10, 32'h1111_1111);
    preload(20, 32'h2222_2222);
    @(negedge clk);
    rst_n = 1'b1;

    contention();
    do_access("read5", 1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_access("p1_wr511", 1'b1, 1'b1, 32'd511, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    do_access("p1_rd511", 1'b1, 1'b0, 32'd511, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    do_access("oor_rd512", 1'b0, 1'b0, 32'd512, 32'd0, 32'h0, 1'b1, 1'b0);
    do_access("oor_wrmax", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0);
    check("oor_mem0_intact", mem[0], 32'hA5A5_A5A5);
    do_access("held_req", 1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    mid_reset();
    do_access("post_rst", 1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
